// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative multiply/divide unit.
package mdu_pkg;
  localparam int MDU_WIDTH = 32;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;
endpackage

// File: rtl/mult_div_unit_if.sv
// Request/result bundle between the core and the multiply/divide unit.
interface mult_div_unit_if #(parameter int WIDTH = 32);
  logic             Start;
  logic [1:0]       Op;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             HiWrite;
  logic             LoWrite;
  logic [WIDTH-1:0] WriteData;
  logic             Busy;
  logic             Done;
  logic [WIDTH-1:0] Hi;
  logic [WIDTH-1:0] Lo;

  modport master (
    output Start, Op, A, B, HiWrite, LoWrite, WriteData,
    input  Busy, Done, Hi, Lo
  );

  modport slave (
    input  Start, Op, A, B, HiWrite, LoWrite, WriteData,
    output Busy, Done, Hi, Lo
  );
endinterface

// File: rtl/mdu_sign_fix.sv
// Conditional two's-complement negate; doubles as abs() when neg_i is the sign bit.
module mdu_sign_fix #(parameter int WIDTH = 32) (
    input  logic [WIDTH-1:0] val_i,
    input  logic             neg_i,
    output logic [WIDTH-1:0] val_o
);
    assign val_o = neg_i ? (~val_i + WIDTH'(1)) : val_i;
endmodule

// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU engine owning the HI/LO registers.
module mult_div_unit
    import mdu_pkg::*;
#(
    parameter int WIDTH = MDU_WIDTH
) (
    input  logic          Clock,
    input  logic          ResetN,
    mult_div_unit_if.slave bus
);
    localparam int CW = $clog2(WIDTH);

    state_e             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               is_div_q, is_div_d;
    logic               neg_res_q, neg_res_d;
    logic               neg_rem_q, neg_rem_d;
    logic               div0_q, div0_d;
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               done_q, done_d;

    logic               op_signed;
    logic [WIDTH-1:0]   a_abs, b_abs;
    logic [WIDTH:0]     mul_sum, div_trial;
    logic [2*WIDTH-1:0] mul_next, div_next, iter_next;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix;

    assign op_signed = (op_e'(bus.Op) == OP_MULT) || (op_e'(bus.Op) == OP_DIV);

    mdu_sign_fix #(.WIDTH(WIDTH)) u_abs_a (
        .val_i(bus.A), .neg_i(op_signed & bus.A[WIDTH-1]), .val_o(a_abs));
    mdu_sign_fix #(.WIDTH(WIDTH)) u_abs_b (
        .val_i(bus.B), .neg_i(op_signed & bus.B[WIDTH-1]), .val_o(b_abs));

    // Multiply: acc = {partial product, remaining multiplier bits}, shifted right.
    assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, opnd_q};
    assign mul_next = acc_q[0] ? {mul_sum, acc_q[WIDTH-1:1]}
                               : {1'b0, acc_q[2*WIDTH-1:1]};

    // Divide: acc = {remainder, dividend/quotient}, shifted left; restore on borrow.
    assign div_trial = acc_q[2*WIDTH-1:WIDTH-1] - {1'b0, opnd_q};
    assign div_next  = div_trial[WIDTH] ? {acc_q[2*WIDTH-2:0], 1'b0}
                                        : {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};

    assign iter_next = is_div_q ? div_next : mul_next;

    mdu_sign_fix #(.WIDTH(2*WIDTH)) u_fix_prod (
        .val_i(iter_next), .neg_i(neg_res_q), .val_o(prod_fix));
    mdu_sign_fix #(.WIDTH(WIDTH)) u_fix_quo (
        .val_i(iter_next[WIDTH-1:0]), .neg_i(neg_res_q), .val_o(quo_fix));
    mdu_sign_fix #(.WIDTH(WIDTH)) u_fix_rem (
        .val_i(iter_next[2*WIDTH-1:WIDTH]), .neg_i(neg_rem_q), .val_o(rem_fix));

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        is_div_d  = is_div_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        div0_d    = div0_q;
        opnd_d    = opnd_q;
        acc_d     = acc_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.Start) begin
                    state_d   = ST_RUN;
                    cnt_d     = '0;
                    is_div_d  = bus.Op[1];
                    neg_res_d = op_signed & (bus.A[WIDTH-1] ^ bus.B[WIDTH-1]);
                    neg_rem_d = op_signed & bus.A[WIDTH-1];
                    div0_d    = (bus.B == '0);
                    opnd_d    = bus.Op[1] ? b_abs : a_abs;
                    acc_d     = bus.Op[1] ? {{WIDTH{1'b0}}, a_abs} : {{WIDTH{1'b0}}, b_abs};
                end else begin
                    if (bus.HiWrite) hi_d = bus.WriteData;
                    if (bus.LoWrite) lo_d = bus.WriteData;
                end
            end
            ST_RUN: begin
                acc_d = iter_next;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH-1)) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    done_d  = 1'b1;
                    if (is_div_q) begin
                        // Divide-by-zero keeps the all-ones quotient unsigned.
                        hi_d = rem_fix;
                        lo_d = div0_q ? {WIDTH{1'b1}} : quo_fix;
                    end else begin
                        {hi_d, lo_d} = prod_fix;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            is_div_q  <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            div0_q    <= 1'b0;
            opnd_q    <= '0;
            acc_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            is_div_q  <= is_div_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            div0_q    <= div0_d;
            opnd_q    <= opnd_d;
            acc_q     <= acc_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            done_q    <= done_d;
        end
    end

    assign bus.Busy = (state_q == ST_RUN);
    assign bus.Done = done_q;
    assign bus.Hi   = hi_q;
    assign bus.Lo   = lo_q;
endmodule

// File: doc/mult_div_unit.md
# mult_div_unit

Iterative 32-bit multiply/divide unit for the MIPS core, consuming the two register-file read operands (ReadData1/ReadData2) and holding results in the architectural HI/LO registers. It executes MULT, MULTU, DIV and DIVU over 32 cycles with a start/busy/done handshake, and supports MTHI/MTLO writes. HI/LO feed the MFHI/MFLO writeback path back into the register file.

## Interface
- Parameters:
- WIDTH, 32, operand and result width; iteration count equals WIDTH.
- Ports:
- Clock  input  1  single clock; all state updates on rising edge.
- ResetN  input  1  asynchronous, active-low reset.
- Start  input  1  request an operation; sampled only when Busy=0.
- Op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU; sampled with Start.
- A  input  WIDTH  rs operand (multiplicand / dividend).
- B  input  WIDTH  rt operand (multiplier / divisor).
- HiWrite  input  1  MTHI: load WriteData into Hi.
- LoWrite  input  1  MTLO: load WriteData into Lo.
- WriteData  input  WIDTH  data for MTHI/MTLO.
- Busy  output  1  operation in progress.
- Done  output  1  one-cycle pulse: Hi/Lo just updated by an operation.
- Hi  output  WIDTH  HI register (product upper half / remainder).
- Lo  output  WIDTH  LO register (product lower half / quotient).

## Operation
- FSM: IDLE -> RUN (WIDTH iterations) -> IDLE. Done is registered and asserted only on the edge leaving RUN.
- IDLE, Start=1: latch Op, |A|, |B| (signed ops) or A, B (unsigned ops), record result signs, clear iteration counter, enter RUN.
- Multiply: shift-add, one multiplier bit per cycle, 2*WIDTH-bit accumulator.
- Divide: restoring shift-subtract, one quotient bit per cycle.
- Sign fix at completion: product negated if operand signs differ; quotient negated if signs differ; remainder takes dividend sign.
- Results: Hi = product[63:32] or remainder; Lo = product[31:0] or quotient.
- Divide by zero (B=0): Hi = A (unmodified dividend), Lo = 0xFFFFFFFF; still takes full WIDTH cycles.
- Signed overflow DIV 0x80000000 / 0xFFFFFFFF: Lo = 0x80000000, Hi = 0 (wrap, no trap).
- Start while Busy=1: ignored, no queueing.
- HiWrite/LoWrite while Busy=1: ignored. In IDLE: register loads on next edge; both may be asserted together.
- Start and HiWrite/LoWrite in the same IDLE cycle: Start wins, writes dropped.
- Hi/Lo otherwise hold value indefinitely; a completed operation overwrites both.

## Timing
- Reset (asynchronous, ResetN=0): Hi=0, Lo=0, Busy=0, Done=0, FSM=IDLE, counter=0. Reset mid-RUN aborts immediately with no Hi/Lo update.
- Start sampled high at edge E (Busy=0): Busy=1 after edge E.
- Iterations on edges E+1 .. E+WIDTH.
- After edge E+WIDTH: Hi/Lo hold new results, Done=1, Busy=0 in the same cycle.
- Done falls after edge E+WIDTH+1. A new Start is accepted at edge E+WIDTH+1, giving back-to-back throughput of one operation per WIDTH+1 cycles.
- MTHI/MTLO latency: one edge.
- A, B, Op need only be valid in the Start cycle.

## Structure
- Shared package mdu_pkg: Op encodings (OP_MULT, OP_MULTU, OP_DIV, OP_DIVU), FSM state enum, default WIDTH.
- Sub-module mdu_sign_fix: combinational abs-value on input and conditional negate on output, instanced for the operand and result paths.
- Top holds the FSM, counter, accumulator/remainder datapath, and Hi/Lo registers.

## Test plan
- MULT A=0xFFFFFFFF, B=0x00000002 -> after 32 iterations, Hi=0xFFFFFFFF, Lo=0xFFFFFFFE; Done is a one-cycle pulse; Busy is high for exactly 32 cycles.
- MULTU same operands -> Hi=0x00000001, Lo=0xFFFFFFFE.
- DIV A=0xFFFFFFF9 (-7), B=2 -> Lo=0xFFFFFFFD, Hi=0xFFFFFFFF; DIVU A=7, B=0 -> Hi=0x00000007, Lo=0xFFFFFFFF.
- DIV A=0x80000000, B=0xFFFFFFFF -> Lo=0x80000000, Hi=0; a second Start pulsed mid-RUN is ignored and the result is unchanged.
- In IDLE, HiWrite=1, WriteData=0x12345678 -> Hi=0x12345678 next edge. HiWrite during Busy -> Hi unchanged. Start+LoWrite together -> operation runs and Lo=result.
- ResetN low 10 cycles into a MULTU -> Hi=Lo=0, Busy=0, no Done pulse. A following MULTU 3x5 -> Hi=0, Lo=0x0000000F.
